// File: rtl/vc_test_multi_port_mem_pkg.sv
// Shared memory message encodings and size helpers for the multi-port test memory.
// Request layout (MSB first): {type, addr, len, data}; response layout: {type, len, data}.
package vc_test_multi_port_mem_pkg;

    typedef enum logic {
        MEM_TYPE_READ  = 1'b0,
        MEM_TYPE_WRITE = 1'b1
    } mem_type_e;

    typedef enum logic [1:0] {
        MEM_LEN_WORD = 2'd0,
        MEM_LEN_BYTE = 2'd1,
        MEM_LEN_HALF = 2'd2
    } mem_len_e;

    // len must hold the halfword code even for narrow data widths
    function automatic int mem_len_sz(input int data_sz);
        int n;
        n = $clog2(data_sz / 8);
        return (n < 2) ? 2 : n;
    endfunction

    function automatic int mem_req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int mem_resp_msg_sz(input int data_sz);
        return 1 + mem_len_sz(data_sz) + data_sz;
    endfunction

endpackage

// File: rtl/vc_test_mem_resp_queue.sv
// Per-port response path: fixed-latency delay line into an in-order FIFO, with an
// outstanding-request counter that throttles request acceptance.
module vc_test_mem_resp_queue
    import vc_test_multi_port_mem_pkg::*;
#(
    parameter int p_msg_sz      = 35,
    parameter int p_latency     = 1,
    parameter int p_queue_depth = 4
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept_i,
    input  logic [p_msg_sz-1:0] msg_i,
    output logic                req_rdy_o,
    output logic                resp_val_o,
    input  logic                resp_rdy_i,
    output logic [p_msg_sz-1:0] resp_msg_o
);

    localparam int c_cnt_sz = $clog2(p_queue_depth + 1);
    localparam int c_ptr_sz = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
    localparam logic [c_cnt_sz-1:0] c_depth = c_cnt_sz'(p_queue_depth);
    localparam logic [c_ptr_sz-1:0] c_last  = c_ptr_sz'(p_queue_depth - 1);

    logic                                    push_val_s;
    logic [p_msg_sz-1:0]                     push_msg_s;
    logic                                    fire_s;
    logic [c_cnt_sz-1:0]                     out_q, out_d, fill_q, fill_d;
    logic [c_ptr_sz-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                                    rdy_q;
    logic [p_queue_depth-1:0][p_msg_sz-1:0]  fifo_q;

    // The FIFO output register is the final latency stage, so only p_latency-1 shift stages precede it.
    if (p_latency == 1) begin : g_no_delay
        assign push_val_s = accept_i;
        assign push_msg_s = msg_i;
    end else begin : g_delay
        localparam int c_stages = p_latency - 1;
        logic [c_stages-1:0]               dl_val_q;
        logic [c_stages-1:0][p_msg_sz-1:0] dl_msg_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dl_val_q <= {c_stages{1'b0}};
                dl_msg_q <= {(c_stages * p_msg_sz){1'b0}};
            end else begin
                dl_val_q[0] <= accept_i;
                dl_msg_q[0] <= msg_i;
                for (int s = 1; s < c_stages; s++) begin
                    dl_val_q[s] <= dl_val_q[s-1];
                    dl_msg_q[s] <= dl_msg_q[s-1];
                end
            end
        end

        assign push_val_s = dl_val_q[c_stages-1];
        assign push_msg_s = dl_msg_q[c_stages-1];
    end

    assign resp_val_o = (fill_q != {c_cnt_sz{1'b0}});
    assign resp_msg_o = fifo_q[rd_ptr_q];
    assign fire_s     = resp_val_o & resp_rdy_i;
    assign req_rdy_o  = rdy_q;

    always_comb begin
        out_d    = out_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept_i && !fire_s) begin
            out_d = out_q + c_cnt_sz'(1);
        end else if (!accept_i && fire_s) begin
            out_d = out_q - c_cnt_sz'(1);
        end else begin
            out_d = out_q;
        end
        if (push_val_s && !fire_s) begin
            fill_d = fill_q + c_cnt_sz'(1);
        end else if (!push_val_s && fire_s) begin
            fill_d = fill_q - c_cnt_sz'(1);
        end else begin
            fill_d = fill_q;
        end
        if (push_val_s) begin
            wr_ptr_d = (wr_ptr_q == c_last) ? {c_ptr_sz{1'b0}} : wr_ptr_q + c_ptr_sz'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fire_s) begin
            rd_ptr_d = (rd_ptr_q == c_last) ? {c_ptr_sz{1'b0}} : rd_ptr_q + c_ptr_sz'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Ready is registered from the next count, so it holds low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= {c_cnt_sz{1'b0}};
            fill_q   <= {c_cnt_sz{1'b0}};
            wr_ptr_q <= {c_ptr_sz{1'b0}};
            rd_ptr_q <= {c_ptr_sz{1'b0}};
            rdy_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= (out_d < c_depth);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q <= {(p_queue_depth * p_msg_sz){1'b0}};
        end else if (push_val_s) begin
            fifo_q[wr_ptr_q] <= push_msg_s;
        end else begin
            fifo_q <= fifo_q;
        end
    end

endmodule

// File: rtl/vc_test_multi_port_mem.sv
// Multi-port test memory: N request/response ports over one shared byte array m,
// accessed in the acceptance cycle, responses returned through per-port latency queues.
module vc_test_multi_port_mem
    import vc_test_multi_port_mem_pkg::*;
#(
    parameter int p_num_ports   = 2,
    parameter int p_mem_sz      = 1024,
    parameter int p_addr_sz     = 16,
    parameter int p_data_sz     = 32,
    parameter int p_latency     = 1,
    parameter int p_queue_depth = 4,
    localparam int c_len_sz      = mem_len_sz(p_data_sz),
    localparam int c_req_msg_sz  = mem_req_msg_sz(p_addr_sz, p_data_sz),
    localparam int c_resp_msg_sz = mem_resp_msg_sz(p_data_sz)
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [p_num_ports-1:0]                memreq_val,
    output logic [p_num_ports-1:0]                memreq_rdy,
    input  logic [p_num_ports*c_req_msg_sz-1:0]   memreq_msg,
    output logic [p_num_ports-1:0]                memresp_val,
    input  logic [p_num_ports-1:0]                memresp_rdy,
    output logic [p_num_ports*c_resp_msg_sz-1:0]  memresp_msg
);

    localparam int c_idx_sz = $clog2(p_mem_sz);
    localparam int c_bytes  = p_data_sz / 8;

    logic [7:0] m [p_mem_sz];

    logic [p_num_ports-1:0]                 acc_s;
    logic [p_num_ports-1:0]                 wr_s;
    logic [p_num_ports-1:0][c_idx_sz-1:0]   idx_s;
    logic [p_num_ports-1:0][c_len_sz-1:0]   len_s;
    logic [p_num_ports-1:0][p_data_sz-1:0]  wdata_s;
    logic [p_num_ports-1:0][c_bytes-1:0]    be_s;

    function automatic logic [c_bytes-1:0] len_be(input logic [c_len_sz-1:0] len);
        logic [c_bytes-1:0] be;
        case (len)
            c_len_sz'(MEM_LEN_BYTE): be = c_bytes'(1'b1);
            c_len_sz'(MEM_LEN_HALF): be = c_bytes'(2'b11);
            default:                 be = {c_bytes{1'b1}};
        endcase
        return be;
    endfunction

    for (genvar i = 0; i < p_num_ports; i++) begin : g_port
        logic [c_req_msg_sz-1:0]  req_s;
        logic [p_data_sz-1:0]     rdata_s;
        logic [c_resp_msg_sz-1:0] resp_s;

        assign req_s      = memreq_msg[i*c_req_msg_sz +: c_req_msg_sz];
        assign wr_s[i]    = (req_s[c_req_msg_sz-1] == MEM_TYPE_WRITE);
        assign idx_s[i]   = c_idx_sz'(req_s[p_data_sz+c_len_sz +: p_addr_sz]);
        assign len_s[i]   = req_s[p_data_sz +: c_len_sz];
        assign wdata_s[i] = req_s[p_data_sz-1:0];
        assign be_s[i]    = len_be(len_s[i]);
        assign acc_s[i]   = memreq_val[i] & memreq_rdy[i];

        // Index arithmetic is c_idx_sz wide, so multi-byte accesses wrap around the array.
        always_comb begin
            rdata_s = {p_data_sz{1'b0}};
            for (int b = 0; b < c_bytes; b++) begin
                if (be_s[i][b]) begin
                    rdata_s[b*8 +: 8] = m[idx_s[i] + c_idx_sz'(b)];
                end else begin
                    rdata_s[b*8 +: 8] = 8'h00;
                end
            end
        end

        assign resp_s = wr_s[i] ? {MEM_TYPE_WRITE, {c_len_sz{1'b0}}, {p_data_sz{1'b0}}}
                                : {MEM_TYPE_READ, len_s[i], rdata_s};

        vc_test_mem_resp_queue #(
            .p_msg_sz      (c_resp_msg_sz),
            .p_latency     (p_latency),
            .p_queue_depth (p_queue_depth)
        ) u_resp_queue (
            .clk        (clk),
            .rst_n      (reset),
            .accept_i   (acc_s[i]),
            .msg_i      (resp_s),
            .req_rdy_o  (memreq_rdy[i]),
            .resp_val_o (memresp_val[i]),
            .resp_rdy_i (memresp_rdy[i]),
            .resp_msg_o (memresp_msg[i*c_resp_msg_sz +: c_resp_msg_sz])
        );
    end

    // Ports are applied in index order so the highest-index writer wins each byte; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_ports; i++) begin
            for (int b = 0; b < c_bytes; b++) begin
                if (acc_s[i] && wr_s[i] && be_s[i][b]) begin
                    m[idx_s[i] + c_idx_sz'(b)] <= wdata_s[i][b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/vc_test_multi_port_mem.md
# vc_test_multi_port_mem

Parametrised test memory for bench use: N independent request/response ports over one shared byte-addressed array, with configurable fixed response latency and per-port response buffering. It sits between random-delay test sources and sinks in unit harnesses for caches and processors that need several memory ports (e.g. instruction plus data) with non-trivial latency. It accepts the standard memory request and response message formats, including word, byte and halfword lengths.

## Interface
- p_num_ports, 2: number of independent ports; legal range 1–4.
- p_mem_sz, 1024: physical memory size in bytes; must be a power of two.
- p_addr_sz, 16: request address field width in bits.
- p_data_sz, 32: data field width in bits; must be a multiple of 8.
- p_latency, 1: cycles from request acceptance to response valid, with an empty queue and the sink ready; must be at least 1.
- p_queue_depth, 4: maximum outstanding requests per port; must be at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memreq_val  in  p_num_ports  per-port request valid.
- memreq_rdy  out  p_num_ports  per-port request ready.
- memreq_msg  in  p_num_ports*c_req_msg_sz  request messages; port i occupies slice i.
- memresp_val  out  p_num_ports  per-port response valid.
- memresp_rdy  in  p_num_ports  per-port response ready.
- memresp_msg  out  p_num_ports*c_resp_msg_sz  response messages; port i occupies slice i.

## Operation
- Request message fields: type (read/write), addr, len, data. Response message fields: type, len, data.
- len encoding: 0 = full word, 1 = byte, 2 = halfword.
- Address handling: the effective address is addr mod p_mem_sz. Multi-byte accesses take consecutive bytes, little-endian, and wrap modulo p_mem_sz. No alignment is required.
- Access timing: the memory access happens in the acceptance cycle (memreq_val & memreq_rdy).
- Read response:
  - type = read, len = request len.
  - data = bytes read, zero-extended.
- Write response:
  - type = write, len = 0, data = 0.
  - Only the len-selected low bytes are written.
- Same-cycle reads see pre-cycle contents. Writes from other ports in that cycle are not visible.
- Same-cycle write conflicts: the highest-index port wins on each overlapping byte.
- Per port, the outstanding count is incremented on accept and decremented on response fire. Simultaneous accept and fire leave it unchanged.
- memreq_rdy[i] = outstanding[i] < p_queue_depth. It never depends on memresp_rdy combinationally.
- Responses on each port are returned in request order. Ports are fully independent, with no cross-port ordering.
- The response path is a p_latency-stage delay line feeding a FIFO sized to p_queue_depth. Because of the credit check, the delay line never stalls and the FIFO never overflows.
- Memory contents are not cleared by reset. Benches preload them hierarchically through array m.

## Timing
- Reset values while reset is low:
  - memreq_rdy = 0, memresp_val = 0.
  - Outstanding counters, delay lines and FIFOs are all cleared.
- Reset mid-operation: in-flight responses are discarded. Writes already accepted remain in memory.
- First acceptance is possible in the first cycle after reset deasserts.
- Latency: a request accepted in cycle t with an empty queue and memresp_rdy held high yields memresp_val in cycle t+p_latency.
- Throughput: one request per cycle per port is sustained whenever p_queue_depth ≥ p_latency+1 and the sink is always ready.
- Backpressure: memresp_msg holds stable while memresp_val is high and memresp_rdy is low.
- Full queue:
  - With outstanding = p_queue_depth, memreq_rdy drops to 0.
  - It rises again in the cycle after a response fires.

## Structure
- Shared message definitions (req/resp size, field macros, type and len encodings) live in the existing memory message header; no new definitions are added there.
- Local constants: c_req_msg_sz, c_resp_msg_sz, c_idx_sz = log2(p_mem_sz), c_cnt_sz = log2(p_queue_depth+1).
- Sub-module vc_test_mem_resp_queue: a per-port delay line, in-order FIFO and outstanding counter. It is instantiated p_num_ports times via generate.
- The top level holds the byte array m and the read/write datapath.

## Test plan
- Basic write/read, p_latency=1, 2 ports:
  - Port 0 writes word 0x0a0b0c0d at 0x0000.
  - Port 1 reads 0x0000 next cycle -> read response 0x0a0b0c0d.
- Subword access:
  - Word 0x0a0b0c0d at 0x0008, then byte write 0xef at 0x0008.
  - Byte reads 0x0008–0x000b -> 0xef, 0x0c, 0x0b, 0x0a.
  - Halfword write 0xbeef at 0x000c over 0x01020304 -> halfword reads give 0xbeef and 0x0102.
- Same-cycle conflict:
  - Ports 0 and 1 both write 0x0010 in one cycle, with 0x11111111 and 0x22222222.
  - A later read returns 0x22222222.
  - A same-cycle read on port 2 returns the old value.
- Latency and backpressure, p_latency=3, p_queue_depth=4:
  - Hold memresp_rdy low and issue 5 reads.
  - memreq_rdy drops after 4 accepts.
  - After releasing memresp_rdy, 4 responses arrive in order, then the 5th is accepted.
- Wrap-around, p_mem_sz=1024:
  - Word write at 0x03fe -> bytes land at 0x3fe, 0x3ff, 0x000, 0x001.
  - Address 0x0400 aliases to 0x0000.
- Reset mid-operation:
  - Assert reset with 3 reads outstanding -> memresp_val goes to 0 immediately.
  - After release, no stale responses appear and earlier writes are still readable.
